level_outcome_unit: RTL and testbench
=====================================

// Module: level_outcome_unit
// PURPOSE
//  Generates win_the_game / lose_the_game for the game-flow FSM from per-frame gameplay conditions.
//  Runs a per-level countdown timer and filters hazard/goal contacts over consecutive frames.
//  Exposes remaining time in binary and BCD for the HUD sprite renderer.
//  Sits between the VGA/collision logic (upstream) and the game-flow FSM (downstream).
// PARAMETERS
//  FRAMES_PER_SEC  60  frame_start pulses per timer second
//  LEVEL0_SECONDS  60  countdown length when selector_value==0 (max 99)
//  LEVEL1_SECONDS  45  countdown length when selector_value!=0 (max 99)
//  HIT_FRAMES      3   consecutive frames with player_hit needed to lose (1..15)
//  GOAL_FRAMES     2   consecutive frames with player_at_goal needed to win (1..15)
// PORTS
//  pixel_clk       in   1  single clock for the whole block
//  reset           in   1  asynchronous, active-high
//  frame_start     in   1  one-cycle pulse per frame (VGA vsync edge)
//  game_state      in   4  flow code: 0 start, 1 prep, 2 play, 3 win screen
//  selector_value  in   2  active level
//  player_hit      in   1  level: player overlaps a hazard this frame
//  player_at_goal  in   1  level: player overlaps the exit tile this frame
//  win_the_game    out  1  registered; level won
//  lose_the_game   out  1  registered; level lost
//  time_left       out  7  remaining whole seconds, binary
//  time_bcd        out  8  remaining seconds, BCD {tens,ones}
//  loss_count      out  8  losses since last start screen, saturating at 255
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0; frame/filter counters 0.
//  States: IDLE, ARMED, RUNNING, WON, LOST.
//  IDLE:  game_state==1 -> load time_left/time_bcd with the level length for selector_value,
//         frame counter=0, filters=0 -> ARMED. game_state==0 -> loss_count=0.
//  ARMED: reload every cycle while game_state==1; game_state==2 -> RUNNING; 0 -> IDLE.
//  RUNNING: only frame_start cycles update. Frame counter counts 0..FRAMES_PER_SEC-1;
//    on wrap, time_left and time_bcd decrement together (BCD ones 0 -> 9 with tens-1).
//    player_hit/player_at_goal sampled on frame_start; each filter increments on 1, clears on 0,
//    and saturates at its threshold.
//    Goal filter reaches GOAL_FRAMES -> WON. Else hit filter reaches HIT_FRAMES, or time_left
//    would go 1 -> 0 -> LOST, loss_count+1 (saturating).
//    Win and lose on the same frame: win has priority. game_state leaving 2 -> IDLE, no outcome.
//  WON/LOST: win_the_game/lose_the_game=1 from the cycle after the transition; held while
//    game_state==2; timer frozen. game_state!=2 -> outputs 0 next cycle, -> IDLE.
//  Outcome latency: 1 cycle after the deciding frame_start.
//  win_the_game and lose_the_game are never both 1.
//  time_left never underflows; it reads 0 in LOST-by-timeout.
//  Reset mid-level: immediate IDLE; outputs 0 with no glitch pulse.
//  frame_start outside RUNNING is ignored.
// STRUCTURE
//  game_pkg: GS_START/GS_PREP/GS_PLAY/GS_WIN 4-bit constants and the outcome_state_t enum.
//  The game-flow FSM imports game_pkg for the same constants.
//  Sub-module frame_persist_filter (param THRESH): consecutive-frame counter with a hit flag.
//  Instantiated twice, once for hit and once for goal.
//  Top level holds the outcome FSM, frame divider and dual binary/BCD countdown.
// TESTING
//  selector_value=0; game_state 1 -> 2; no contacts; 3600 frame_starts.
//    -> time_bcd steps 8'h60 -> 8'h00; lose_the_game=1 one cycle after frame 3600; loss_count=1.
//  player_hit for 2 frames, then 0, then 2 more frames -> no lose.
//    player_hit for 3 consecutive frames -> lose_the_game on cycle after 3rd frame_start.
//  player_at_goal and player_hit both held 3 frames (GOAL_FRAMES=2).
//    -> win_the_game=1 after frame 2; lose_the_game stays 0.
//  Win, then game_state 2 -> 1 -> win deasserts the next cycle.
//    Then selector_value=1 -> time_left reloads to 45, time_bcd=8'h45.
//  Assert reset while RUNNING with time_left=30 -> all outputs 0 immediately.
//    Release; game_state=0 -> loss_count stays 0; state IDLE.
//  Lose 256 times via hit -> loss_count saturates at 255.
//    Then game_state=0 -> loss_count=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow constants and the outcome FSM state type.
// The game-flow FSM imports this package so both sides agree on the codes.
package game_pkg;

   localparam logic [3:0] GS_START = 4'd0;
   localparam logic [3:0] GS_PREP  = 4'd1;
   localparam logic [3:0] GS_PLAY  = 4'd2;
   localparam logic [3:0] GS_WIN   = 4'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RUNNING,
      ST_WON,
      ST_LOST
   } outcome_state_t;

   // Level lengths are at most 99, so two BCD digits always suffice.
   function automatic logic [7:0] to_bcd(input int value);
      return {4'(value / 10), 4'(value % 10)};
   endfunction

endpackage

// File: rtl/frame_persist_filter.sv
// Consecutive-frame contact filter: counts frames with the contact level high,
// clears on any frame without it, and saturates at THRESH.
module frame_persist_filter #(
   parameter int THRESH = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic sample,
   input  logic level,
   output logic reached
);

   localparam logic [3:0] THRESH_CNT  = 4'(THRESH);
   localparam logic [3:0] THRESH_LAST = 4'(THRESH - 1);

   logic [3:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (sample) begin
         if (!level)
            count <= '0;
         else if (count < THRESH_CNT)
            count <= count + 4'd1;
      end
   end

   // Flags the frame on which the count arrives at (or stays at) the threshold.
   assign reached = sample && level && (count >= THRESH_LAST);

endmodule

// File: rtl/level_outcome_unit.sv
// Per-level outcome generator: countdown timer (binary + BCD), hit/goal filters,
// and the outcome FSM feeding win/lose to the game-flow FSM.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no level in progress; start screen clears loss_count
// ST_ARMED   | prep screen; timer and filters reloaded every cycle
// ST_RUNNING | level in play; frame_start drives timer and filters
// ST_WON     | goal reached; win_the_game held while still in play
// ST_LOST    | hit or timeout; lose_the_game held while still in play
module level_outcome_unit
   import game_pkg::*;
#(
   parameter int FRAMES_PER_SEC = 60,
   parameter int LEVEL0_SECONDS = 60,
   parameter int LEVEL1_SECONDS = 45,
   parameter int HIT_FRAMES     = 3,
   parameter int GOAL_FRAMES    = 2
) (
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic [3:0] game_state,
   input  logic [1:0] selector_value,
   input  logic       player_hit,
   input  logic       player_at_goal,
   output logic       win_the_game,
   output logic       lose_the_game,
   output logic [6:0] time_left,
   output logic [7:0] time_bcd,
   output logic [7:0] loss_count
);

   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
   localparam logic [6:0]    LEN0       = 7'(LEVEL0_SECONDS);
   localparam logic [6:0]    LEN1       = 7'(LEVEL1_SECONDS);
   localparam logic [7:0]    LEN0_BCD   = to_bcd(LEVEL0_SECONDS);
   localparam logic [7:0]    LEN1_BCD   = to_bcd(LEVEL1_SECONDS);

   outcome_state_t state, next_state;
   logic [FW-1:0]  frame_cnt;
   logic           load;
   logic           play_frame;
   logic           tick;
   logic           timeout;
   logic           hit_reached;
   logic           goal_reached;
   logic           lose_event;

   assign load       = ((state == ST_IDLE) || (state == ST_ARMED)) && (game_state == GS_PREP);
   assign play_frame = (state == ST_RUNNING) && (game_state == GS_PLAY) && frame_start;
   assign tick       = play_frame && (frame_cnt == FRAME_LAST);
   assign timeout    = tick && (time_left == 7'd1);

   frame_persist_filter #(.THRESH(HIT_FRAMES)) u_hit_filter (
      .clk     (pixel_clk),
      .reset   (reset),
      .clear   (load),
      .sample  (play_frame),
      .level   (player_hit),
      .reached (hit_reached)
   );

   frame_persist_filter #(.THRESH(GOAL_FRAMES)) u_goal_filter (
      .clk     (pixel_clk),
      .reset   (reset),
      .clear   (load),
      .sample  (play_frame),
      .level   (player_at_goal),
      .reached (goal_reached)
   );

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         win_the_game  <= 1'b0;
         lose_the_game <= 1'b0;
      end else begin
         state         <= next_state;
         win_the_game  <= (next_state == ST_WON);
         lose_the_game <= (next_state == ST_LOST);
      end
   end

   always_comb begin
      next_state = state;
      lose_event = 1'b0;
      case (state)
         ST_IDLE: begin
            if (game_state == GS_PREP)
               next_state = ST_ARMED;
         end
         ST_ARMED: begin
            if (game_state == GS_PLAY)
               next_state = ST_RUNNING;
            else if (game_state == GS_START)
               next_state = ST_IDLE;
         end
         ST_RUNNING: begin
            // Win outranks a hit or timeout landing on the same frame.
            if (game_state != GS_PLAY) begin
               next_state = ST_IDLE;
            end else if (goal_reached) begin
               next_state = ST_WON;
            end else if (hit_reached || timeout) begin
               next_state = ST_LOST;
               lose_event = 1'b1;
            end
         end
         ST_WON, ST_LOST: begin
            if (game_state != GS_PLAY)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         time_left <= '0;
         time_bcd  <= '0;
      end else if (load) begin
         frame_cnt <= '0;
         time_left <= (selector_value == 2'd0) ? LEN0 : LEN1;
         time_bcd  <= (selector_value == 2'd0) ? LEN0_BCD : LEN1_BCD;
      end else if (play_frame) begin
         frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
         if (tick && (time_left != 7'd0)) begin
            time_left <= time_left - 7'd1;
            if (time_bcd[3:0] == 4'd0)
               time_bcd <= {time_bcd[7:4] - 4'd1, 4'd9};
            else
               time_bcd <= {time_bcd[7:4], time_bcd[3:0] - 4'd1};
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset)
         loss_count <= '0;
      else if ((state == ST_IDLE) && (game_state == GS_START))
         loss_count <= '0;
      else if (lose_event && (loss_count != 8'hFF))
         loss_count <= loss_count + 8'd1;
   end

endmodule

// File: tb/tb_level_outcome_unit.sv
// Self-checking bench for level_outcome_unit: directed scenarios plus random
// play, every cycle compared against a behavioural model of the level rules.
module tb_level_outcome_unit;

   localparam int FPS   = 60;
   localparam int L0    = 60;
   localparam int L1    = 45;
   localparam int HITN  = 3;
   localparam int GOALN = 2;

   localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_WON = 3, P_LOST = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic [3:0] game_state = 4'd0;
   logic [1:0] selector_value = 2'd0;
   logic       player_hit = 1'b0;
   logic       player_at_goal = 1'b0;
   logic       win_the_game;
   logic       lose_the_game;
   logic [6:0] time_left;
   logic [7:0] time_bcd;
   logic [7:0] loss_count;

   int errors = 0;
   int checks = 0;

   int m_phase, m_frames, m_secs, m_hit_run, m_goal_run, m_loss;

   always #5 clk = ~clk;

   level_outcome_unit #(
      .FRAMES_PER_SEC (FPS),
      .LEVEL0_SECONDS (L0),
      .LEVEL1_SECONDS (L1),
      .HIT_FRAMES     (HITN),
      .GOAL_FRAMES    (GOALN)
   ) dut (
      .pixel_clk      (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .game_state     (game_state),
      .selector_value (selector_value),
      .player_hit     (player_hit),
      .player_at_goal (player_at_goal),
      .win_the_game   (win_the_game),
      .lose_the_game  (lose_the_game),
      .time_left      (time_left),
      .time_bcd       (time_bcd),
      .loss_count     (loss_count)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_frames = 0; m_secs = 0;
      m_hit_run = 0; m_goal_run = 0; m_loss = 0;
   endtask

   task automatic model_load();
      m_secs = (selector_value == 2'd0) ? L0 : L1;
      m_frames = 0; m_hit_run = 0; m_goal_run = 0;
      m_phase = P_ARMED;
   endtask

   task automatic model_step();
      bit tick;
      case (m_phase)
         P_IDLE: begin
            if (game_state == 4'd1) model_load();
            else if (game_state == 4'd0) m_loss = 0;
         end
         P_ARMED: begin
            if (game_state == 4'd1) model_load();
            else if (game_state == 4'd2) m_phase = P_RUN;
            else if (game_state == 4'd0) m_phase = P_IDLE;
         end
         P_RUN: begin
            if (game_state != 4'd2) begin
               m_phase = P_IDLE;
            end else if (frame_start) begin
               m_frames++;
               tick = (m_frames % FPS) == 0;
               m_hit_run  = player_hit     ? m_hit_run + 1  : 0;
               m_goal_run = player_at_goal ? m_goal_run + 1 : 0;
               if (m_goal_run >= GOALN) begin
                  m_phase = P_WON;
               end else if (m_hit_run >= HITN || (tick && m_secs == 1)) begin
                  m_phase = P_LOST;
                  if (m_loss < 255) m_loss++;
               end
               if (tick && m_secs > 0) m_secs--;
            end
         end
         default: begin
            if (game_state != 4'd2) m_phase = P_IDLE;
         end
      endcase
   endtask

   task automatic check_outputs();
      check("win", win_the_game, m_phase == P_WON);
      check("lose", lose_the_game, m_phase == P_LOST);
      check("time_left", time_left, m_secs);
      check("time_bcd", time_bcd, ((m_secs / 10) << 4) | (m_secs % 10));
      check("loss_count", loss_count, m_loss);
      check("exclusive", win_the_game & lose_the_game, 0);
   endtask

   task automatic cyc(input bit fs, input int gs, input int sel, input bit hit, input bit goal);
      frame_start = fs; game_state = 4'(gs); selector_value = 2'(sel);
      player_hit = hit; player_at_goal = goal;
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      check_outputs();
   endtask

   initial begin
      model_reset();
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, 0);
      check("rst_win", win_the_game, 0);
      check("rst_time", time_left, 0);

      // Full level-0 timeout with frames every other cycle.
      cyc(0, 1, 0, 0, 0);
      check("load60_bcd", time_bcd, 8'h60);
      cyc(0, 2, 0, 0, 0);
      for (int f = 1; f < 3600; f++) begin
         cyc(1, 2, 0, 0, 0);
         cyc(0, 2, 0, 0, 0);
      end
      check("pre_timeout_lose", lose_the_game, 0);
      check("pre_timeout_bcd", time_bcd, 8'h01);
      cyc(1, 2, 0, 0, 0);
      check("timeout_lose", lose_the_game, 1);
      check("timeout_bcd", time_bcd, 8'h00);
      check("timeout_loss", loss_count, 1);
      cyc(0, 2, 0, 0, 0);
      check("timeout_hold", lose_the_game, 1);
      cyc(0, 1, 0, 0, 0);
      check("timeout_release", lose_the_game, 0);

      // Hit filter: broken run does not lose, third consecutive does.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 2, 0, 0, 0);
      cyc(1, 2, 0, 1, 0);
      cyc(1, 2, 0, 1, 0);
      cyc(1, 2, 0, 0, 0);
      cyc(1, 2, 0, 1, 0);
      cyc(1, 2, 0, 1, 0);
      check("hit_broken_nolose", lose_the_game, 0);
      cyc(1, 2, 0, 1, 0);
      check("hit_third_lose", lose_the_game, 1);
      check("hit_loss", loss_count, 2);

      // Goal and hit together: goal wins after two frames.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 2, 0, 0, 0);
      cyc(1, 2, 0, 1, 1);
      check("goal_f1_win", win_the_game, 0);
      cyc(1, 2, 0, 1, 1);
      check("goal_win", win_the_game, 1);
      cyc(1, 2, 0, 1, 1);
      check("goal_nolose", lose_the_game, 0);
      check("goal_hold", win_the_game, 1);
      cyc(0, 1, 0, 0, 0);
      check("win_release", win_the_game, 0);
      cyc(0, 1, 1, 0, 0);
      check("load45_bin", time_left, 45);
      check("load45_bcd", time_bcd, 8'h45);

      // Reset mid-level with 30 seconds left.
      cyc(0, 2, 1, 0, 0);
      for (int f = 0; f < 15 * FPS; f++) cyc(1, 2, 1, 0, 0);
      check("mid_time30", time_left, 30);
      #2 reset = 1'b1;
      #1;
      check("async_win", win_the_game, 0);
      check("async_lose", lose_the_game, 0);
      check("async_time", time_left, 0);
      check("async_bcd", time_bcd, 0);
      check("async_loss", loss_count, 0);
      model_reset();
      cyc(0, 2, 1, 0, 0);
      reset = 1'b0;
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      check("post_rst_loss", loss_count, 0);

      // Loss counter saturation.
      for (int n = 0; n < 256; n++) begin
         cyc(0, 1, 0, 0, 0);
         cyc(0, 1, 0, 0, 0);
         cyc(0, 2, 0, 0, 0);
         cyc(1, 2, 0, 1, 0);
         cyc(1, 2, 0, 1, 0);
         cyc(1, 2, 0, 1, 0);
      end
      check("loss_sat", loss_count, 255);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("loss_clear", loss_count, 0);

      // Random play against the model.
      for (int i = 0; i < 4000; i++) begin
         int r, gs;
         r = $urandom_range(0, 99);
         gs = (r < 80) ? 2 : (r < 90) ? 1 : (r < 96) ? 0 : 3;
         cyc(($urandom_range(0, 2) == 0), gs, $urandom_range(0, 3),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
